// File: rtl/seq_divider.sv
// Sequential restoring divider: one shift-subtract step per clock, start/busy/done handshake.
// Divide-by-zero completes immediately with an all-ones quotient and a sticky flag.
module seq_divider #(
    parameter int unsigned DW = 6,
    parameter int unsigned VW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned RW = VW + 1;
    localparam int unsigned TW = VW + 2;
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          r_state;
    logic [RW-1:0]   r_rem;
    logic [DW-1:0]   r_q;
    logic [VW-1:0]   r_d;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_dbz;
    logic [DW-1:0]   r_quot;
    logic [VW-1:0]   r_remo;

    logic [TW-1:0]   w_t;
    logic [TW-1:0]   w_diff;
    logic            w_ge;
    logic [RW-1:0]   w_rnext;
    logic [DW-1:0]   w_qnext;

    // One restoring step; the top bit of R is always 0, so the wide trial value truncates safely.
    always_comb begin
        w_t     = {r_rem, r_q[DW-1]};
        w_diff  = w_t - TW'(r_d);
        w_ge    = (w_t >= TW'(r_d));
        w_rnext = RW'(w_ge ? w_diff : w_t);
        w_qnext = {r_q[DW-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (divisor != '0) begin
                            r_rem   <= '0;
                            r_q     <= dividend;
                            r_d     <= divisor;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_dbz   <= 1'b0;
                            r_state <= S_RUN;
                        end else begin
                            r_done <= 1'b1;
                            r_dbz  <= 1'b1;
                            r_quot <= '1;
                            r_remo <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rnext;
                    r_q   <= w_qnext;
                    r_cnt <= r_cnt + CW'(1);
                    // Final step publishes its own result directly, so outputs never show partial values.
                    if (r_cnt == CW'(DW - 1)) begin
                        r_quot  <= w_qnext;
                        r_remo  <= w_rnext[VW-1:0];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, reset abort, back-to-back sweep, random ops.
// Expected results come from integer / and % on the operands.
module tb_seq_divider;

    localparam int unsigned DW = 6;
    localparam int unsigned VW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_q;
    logic [VW-1:0] exp_r;
    logic          exp_z;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    // Reference: plain unsigned division, all-ones quotient on divide-by-zero.
    task automatic model(input int a, input int b);
        if (b == 0) begin
            exp_q = '1;
            exp_r = '0;
            exp_z = 1'b1;
        end else begin
            exp_q = DW'(a / b);
            exp_r = VW'(a % b);
            exp_z = 1'b0;
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_q"}, 32'(quotient), 32'(exp_q));
        check({tag, "_r"}, 32'(remainder), 32'(exp_r));
        check({tag, "_z"}, 32'(div_by_zero), 32'(exp_z));
    endtask

    // One operation from IDLE; noisy=1 toggles start and scrambles operands while busy.
    task automatic run_div(input int a, input int b, input bit noisy);
        int j;
        int busy_n;
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = VW'(b);
        @(negedge clk);
        j = 0;
        busy_n = 0;
        while (!done && j < 40) begin
            if (busy) busy_n++;
            check("hold_q", 32'(quotient), 32'(exp_q));
            check("hold_r", 32'(remainder), 32'(exp_r));
            if (noisy) begin
                start    = 1'($urandom_range(0, 1));
                dividend = DW'($urandom);
                divisor  = VW'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        model(a, b);
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(j), (b == 0) ? 32'd0 : 32'(DW));
        check("busy_cycles", 32'(busy_n), (b == 0) ? 32'd0 : 32'(DW));
        check("busy_at_done", 32'(busy), 32'd0);
        check_results("result");
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check_results("held");
    endtask

    // Start held high across all 0..63 / 1..7 pairs; done must recur every DW+1 cycles.
    task automatic sweep();
        int j;
        for (int a = 0; a < 64; a++) begin
            for (int b = 1; b < 8; b++) begin
                start    = 1'b1;
                dividend = DW'(a);
                divisor  = VW'(b);
                j = 0;
                do begin
                    @(negedge clk);
                    j++;
                end while (!done && j < 40);
                model(a, b);
                check("sweep_spacing", 32'(j), 32'(DW + 1));
                check_results("sweep");
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("sweep_end_done", 32'(done), 32'd0);
    endtask

    task automatic reset_abort();
        int dn;
        start    = 1'b1;
        dividend = DW'(33);
        divisor  = VW'(4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy3", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q = '0;
        exp_r = '0;
        exp_z = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check_results("abort");
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q = '0;
        exp_r = '0;
        exp_z = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check_results("reset");

        run_div(45, 6, 1'b0);
        run_div(63, 7, 1'b0);
        run_div(5, 7, 1'b0);
        run_div(0, 1, 1'b0);
        run_div(20, 0, 1'b0);
        run_div(12, 4, 1'b0);
        run_div(49, 5, 1'b1);

        reset_abort();
        run_div(33, 4, 1'b0);

        sweep();

        repeat (40) run_div(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                            1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring binary divider. It is the inverse companion of the team's 3-bit x 3-bit combinational multiplier.
- Divides a DW-bit dividend by a VW-bit divisor using one shift-subtract step per clock.
- Produces a registered quotient and remainder, and reports completion with a start/busy/done handshake.
- Results feed the existing binary-to-BCD and seven-segment display path at the top level; that path is not part of this block.

Parameters:
- DW, 6, dividend and quotient width in bits (default covers the full 6-bit product range 0..63).
- VW, 3, divisor and remainder width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to begin a division; sampled only in IDLE.
- dividend  input  DW  dividend; sampled on the accepting edge.
- divisor  input  VW  divisor; sampled on the accepting edge.
- busy  output  1  high while an iteration sequence is in progress.
- done  output  1  single-cycle pulse; quotient and remainder are valid.
- quotient  output  DW  registered quotient; held until the next accepted start.
- remainder  output  VW  registered remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when the sampled divisor was 0; held until the next accepted start.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state goes to IDLE. busy, done, div_by_zero and the step counter become 0; quotient and remainder become 0. A reset mid-operation aborts the division with no done pulse.
- Internal registers:
  - partial remainder R, VW+1 bits
  - shift register Q, DW bits
  - latched divisor D, VW bits
  - step counter, wide enough to hold DW-1
- States: IDLE, RUN.
- IDLE, start=1, divisor!=0, at edge k:
  - R<=0, Q<=dividend, D<=divisor, counter<=0, busy<=1, done<=0, div_by_zero<=0.
  - Next state is RUN.
- IDLE, start=1, divisor==0, at edge k:
  - No RUN state is entered.
  - done<=1 (one cycle), div_by_zero<=1, quotient<=all ones (63 at default), remainder<=0.
  - busy stays 0.
- IDLE, start=0: done<=0; all other outputs hold.
- RUN, each edge:
  - T = {R[VW-1:0], Q[DW-1]}, Q <= Q<<1.
  - If T >= {1'b0,D}: R <= T - D and Q[0] <= 1. Otherwise R <= T and Q[0] <= 0.
  - Counter increments by 1.
- RUN, final step (counter==DW-1, edge k+DW):
  - The step above executes, and its results go directly to quotient and remainder (remainder = low VW bits of the new R).
  - done<=1, busy<=0, state goes to IDLE.
- Latency: start accepted at edge k gives done high in the cycle after edge k+DW (6 cycles at default). busy is high for exactly DW cycles.
- start while busy: ignored, no effect on the operation in progress. dividend and divisor changes during RUN are also ignored.
- start in the cycle where done=1: accepted, since state is IDLE. done drops at that edge and the new operation begins, giving back-to-back throughput of one result per DW+1 cycles.
- Arithmetic: unsigned only. The invariant dividend = quotient*divisor + remainder with remainder < divisor must hold for every nonzero divisor. R never exceeds 2*D-1 and therefore fits in VW+1 bits.
- quotient and remainder change only at completion (RUN final step or divide-by-zero) or reset. They never show intermediate values.

Test Plan:
- Reset, then start with dividend=45, divisor=6 -> busy high 6 cycles; done pulses 6 cycles after the accepting edge; quotient=7, remainder=3, div_by_zero=0.
- Dividend=63, divisor=7 -> quotient=9, remainder=0. Dividend=5, divisor=7 -> quotient=0, remainder=5. Dividend=0, divisor=1 -> quotient=0, remainder=0.
- Dividend=20, divisor=0 -> done in the next cycle, busy never high, quotient=63, remainder=0, div_by_zero=1. A following 12/4 -> quotient=3, remainder=0, div_by_zero=0.
- Start 49/5; pulse start with 10/2 and change inputs during busy -> inputs ignored; result quotient=9, remainder=4.
- Start 33/4; assert rst on the 3rd busy cycle -> all outputs 0 the next cycle, no done pulse. A subsequent 33/4 gives quotient=8, remainder=1.
- Exhaustive sweep of 0..63 by 1..7 with start held high continuously -> each result matches the invariant, and done spacing is exactly 7 cycles.
